// File: rtl/sum_window_accumulator.sv
// Accumulates 2**LOG2_N accepted samples and presents the window total and truncated mean on a valid/ready port.
// Optional macro SUM_ACC_BACK2BACK_EN: accept the next window's first sample in the same cycle the held result completes.
module sum_window_accumulator #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 2,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_avg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOG2_N-1:0] sample_cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'((1 << LOG2_N) - 1);
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

    state_t              state_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    out_sum_reg;
    logic [DATA_W-1:0]   out_avg_reg;
    logic [LOG2_N-1:0]   cnt_reg;

    logic                accept;
    logic                complete;
    logic [ACC_W-1:0]    total_next;
    logic [DATA_W-1:0]   avg_next;

    // in_ready already carries ena, so accept is ena-qualified through it.
    always_comb begin
        in_ready = 1'b0;
        if (ena) begin
            if (state_reg == ACCUM) begin
                in_ready = 1'b1;
            end
`ifdef SUM_ACC_BACK2BACK_EN
            else begin
                in_ready = out_ready;
            end
`endif
        end
    end

    assign accept     = in_valid & in_ready;
    assign complete   = ena & out_valid & out_ready;
    assign total_next = acc_reg + ACC_W'(in_data);
    assign avg_next   = total_next[LOG2_N +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ACCUM;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            out_sum_reg <= '0;
            out_avg_reg <= '0;
        end else if (ena) begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        if (cnt_reg == CNT_LAST) begin
                            out_sum_reg <= total_next;
                            out_avg_reg <= avg_next;
                            acc_reg     <= '0;
                            cnt_reg     <= '0;
                            state_reg   <= HOLD;
                        end else begin
                            acc_reg <= total_next;
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (complete) begin
                        state_reg <= ACCUM;
`ifdef SUM_ACC_BACK2BACK_EN
                        // Zero-bubble turnover: first sample of the next window lands now.
                        if (accept) begin
                            acc_reg <= ACC_W'(in_data);
                            cnt_reg <= CNT_ONE;
                        end
`endif
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    assign out_valid  = (state_reg == HOLD);
    assign out_sum    = out_sum_reg;
    assign out_avg    = out_avg_reg;
    assign sample_cnt = cnt_reg;

endmodule
